// File: rtl/alu_exec_unit.sv
// Registered, handshaked execute-stage ALU for the RV32I core.
// add/sub/and/or/slt finish in one cycle; sll/srl/sra shift one bit
// per cycle through an internal accumulator.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic { IDLE, SHIFT } state_e;
  typedef enum logic [1:0] { SH_LL, SH_RL, SH_RA } shift_e;

  state_e             state;
  shift_e             shift_op;
  shift_e             shift_dec;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_value;
  logic               accept;
  logic               is_shift;
  logic               slt_bit;

  // Handshake: only accept when idle and the output register is free or draining now
  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    shamt    = src_b[SHAMT_W-1:0];
    is_shift = alu_control[2] && (alu_control != OP_SLT);
  end

  // Single-cycle operation results and shift-kind decode
  always_comb begin
    slt_bit   = ($signed(src_a) < $signed(src_b));
    alu_value = '0;
    shift_dec = SH_LL;
    case (alu_control)
      OP_ADD:  alu_value = src_a + src_b;
      OP_SUB:  alu_value = src_a - src_b;
      OP_AND:  alu_value = src_a & src_b;
      OP_OR:   alu_value = src_a | src_b;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  shift_dec = SH_LL;
      OP_SRL:  shift_dec = SH_RL;
      OP_SRA:  shift_dec = SH_RA;
      default: alu_value = '0;
    endcase
  end

  // One-bit shift of the accumulator for the latched shift kind
  always_comb begin
    acc_next = acc;
    case (shift_op)
      SH_LL:   acc_next = {acc[WIDTH-2:0], 1'b0};
      SH_RL:   acc_next = {1'b0, acc[WIDTH-1:1]};
      SH_RA:   acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_next = acc;
    endcase
  end

  // Control FSM, accumulator/counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_op  <= SH_LL;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // A new result written below on the same edge overrides this drain
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_shift) begin
              result    <= alu_value;
              zero      <= (alu_value == '0);
              out_valid <= 1'b1;
            end else if (shamt == '0) begin
              result    <= src_a;
              zero      <= (src_a == '0);
              out_valid <= 1'b1;
            end else begin
              acc      <= src_a;
              cnt      <= shamt;
              shift_op <= shift_dec;
              busy     <= 1'b1;
              state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= acc_next;
            zero      <= (acc_next == '0);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases, backpressure,
// mid-shift reset and a randomized run against a behavioural reference.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: plain operators on the decoded operation
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    logic signed [31:0] s;
    n = b[4:0];
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return a << n;
      3'b110:  return a >> n;
      default: begin
        s = $signed(a) >>> n;
        return s;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, keep in_valid asserted with garbage
  // operands while waiting (must be ignored), then check result and latency.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int unsigned n;
    int unsigned exp_lat;
    int unsigned lat;
    logic got;
    exp = model(op, a, b);
    n = b[4:0];
    exp_lat = (op[2] && op != 3'b101 && n != 0) ? 1 + n : 1;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    out_ready   = 1'b1;
    check1({tag, " in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    alu_control = 3'($urandom);
    src_a       = $urandom;
    src_b       = $urandom;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
      end else begin
        lat++;
        check1({tag, " busy"}, busy, 1'b1);
        check1({tag, " in_ready_low"}, in_ready, 1'b0);
      end
    end
    in_valid = 1'b0;
    check1({tag, " out_valid"}, got, 1'b1);
    check({tag, " result"}, result, exp);
    check1({tag, " zero"}, zero, (exp == 32'd0));
    check({tag, " latency"}, lat, exp_lat);
    check1({tag, " busy_done"}, busy, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst out_valid", out_valid, 1'b0);
    check("rst result", result, 32'd0);
    check1("rst zero", zero, 1'b0);
    check1("rst busy", busy, 1'b0);
    check1("rst in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Directed single-cycle ops
    run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'd1);
    run_op("sub_zero", 3'b001, 32'd5, 32'd5);
    run_op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd1);
    run_op("slt_pos", 3'b101, 32'd1, 32'hFFFF_FFFF);
    run_op("and", 3'b010, 32'h0000_F0F0, 32'h0000_0FF0);
    run_op("or", 3'b011, 32'h0000_F0F0, 32'h0000_0FF0);

    // Iterative shifts, including the maximum amount and shamt 0
    run_op("sra31", 3'b111, 32'h8000_0000, 32'd31);
    run_op("srl31", 3'b110, 32'h8000_0000, 32'd31);
    run_op("sll_sh0", 3'b100, 32'h0000_0001, 32'h0000_0020);
    run_op("sll4", 3'b100, 32'h0000_0001, 32'd4);
    run_op("sll_to_zero", 3'b100, 32'h0000_0002, 32'd31);

    // Backpressure: result held, new request ignored until output is consumed
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 3'b000;
    src_a       = 32'd100;
    src_b       = 32'd23;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    src_a = 32'h0000_1000;
    src_b = 32'h0000_0234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("bp out_valid", out_valid, 1'b1);
      check("bp result", result, 32'd123);
      check1("bp in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check1("bp release in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check1("b2b out_valid", out_valid, 1'b1);
    check("b2b result", result, 32'h0000_1234);
    check1("b2b zero", zero, 1'b0);
    @(negedge clk);
    check1("b2b drained", out_valid, 1'b0);

    // Reset in the middle of a 20-bit sll
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 3'b100;
    src_a       = 32'h0000_0003;
    src_b       = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check1("midrst busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst out_valid", out_valid, 1'b0);
    check1("midrst busy", busy, 1'b0);
    check("midrst result", result, 32'd0);
    check1("midrst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check1("midrst no_result", out_valid, 1'b0);
    end
    run_op("post_rst_sll", 3'b100, 32'h0000_0003, 32'd20);

    // Randomized run
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (($urandom % 4) == 0) b = a;
      run_op("rand", op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
